// File: rtl/mc_refresh_scheduler.sv
// rtl/mc_refresh_scheduler.sv - LPDDR4 all-bank refresh scheduler (interval, debt, PREA/REF sequencing)
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ref_en_i               refresh enable (DFI init complete)
//   ref_trefi_cfg_i        refresh interval in clk cycles (0 disables ticks)
//   ref_postpone_cfg_i     pending count at which the request becomes urgent
//   ref_trp_cfg_i          PREA-to-REF spacing (0 treated as 1)
//   ref_trfc_cfg_i         REF-to-release spacing (0 treated as 1)
//   ref_gnt_i              single-cycle grant from the command multiplexer
//   ref_req_o              refresh slot request
//   ref_urgent_o           debt at/above postpone limit; block new ACT/RD/WR
//   ref_busy_o             scheduler owns the command bus
//   cmd_prea_o, cmd_ref_o  one-cycle precharge-all / all-bank refresh pulses
//   ref_pending_o          current refresh debt
//   ref_ovf_o              sticky: tick arrived while debt was saturated
module mc_refresh_scheduler #(
    parameter int TREFI_W = 12,
    parameter int POST_W  = 4,
    parameter int T_W     = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ref_en_i,
    input  logic [TREFI_W-1:0] ref_trefi_cfg_i,
    input  logic [POST_W-1:0]  ref_postpone_cfg_i,
    input  logic [T_W-1:0]     ref_trp_cfg_i,
    input  logic [T_W-1:0]     ref_trfc_cfg_i,
    input  logic               ref_gnt_i,
    output logic               ref_req_o,
    output logic               ref_urgent_o,
    output logic               ref_busy_o,
    output logic               cmd_prea_o,
    output logic               cmd_ref_o,
    output logic [POST_W-1:0]  ref_pending_o,
    output logic               ref_ovf_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC
    } state_t;

    state_t             state_q, state_d;
    logic [T_W-1:0]     timer_q, timer_d;
    logic [TREFI_W-1:0] int_cnt_q, int_cnt_d;
    logic [POST_W-1:0]  pending_q, pending_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, prea_q, ref_q;

    logic               run;
    logic               tick;
    logic               req;
    logic [T_W-1:0]     trp_load;
    logic [T_W-1:0]     trfc_load;

    // The >= guards against a tREFI reduction below the current count,
    // which would otherwise run the counter all the way around.
    assign run       = ref_en_i && (ref_trefi_cfg_i != '0);
    assign tick      = run && (int_cnt_q >= (ref_trefi_cfg_i - 1'b1));
    assign int_cnt_d = (!run || tick) ? '0 : int_cnt_q + 1'b1;

    // A zero spacing is treated as one cycle of wait.
    assign trp_load  = (ref_trp_cfg_i  == '0) ? '0 : ref_trp_cfg_i  - 1'b1;
    assign trfc_load = (ref_trfc_cfg_i == '0) ? '0 : ref_trfc_cfg_i - 1'b1;

    assign req = (state_q == S_IDLE) && ref_en_i && (pending_q != '0);

    // Debt bookkeeping: the REF pulse retires one refresh in the same cycle
    // a tick may add one, so both together leave the count unchanged.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (tick && !ref_q) begin
            if (&pending_q) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!tick && ref_q) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (ref_gnt_i && req) begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                timer_d = trp_load;
                state_d = S_WAIT_RP;
            end
            S_WAIT_RP: begin
                if (timer_q == '0) begin
                    state_d = S_REF;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_REF: begin
                timer_d = trfc_load;
                state_d = S_WAIT_RFC;
            end
            S_WAIT_RFC: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            int_cnt_q <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            prea_q    <= 1'b0;
            ref_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            int_cnt_q <= int_cnt_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            // Command/busy flops follow the next state so they align with it.
            busy_q    <= (state_d != S_IDLE);
            prea_q    <= (state_d == S_PRE);
            ref_q     <= (state_d == S_REF);
        end
    end

    assign ref_req_o     = req;
    assign ref_urgent_o  = (pending_q >= ref_postpone_cfg_i) && (pending_q != '0);
    assign ref_busy_o    = busy_q;
    assign cmd_prea_o    = prea_q;
    assign cmd_ref_o     = ref_q;
    assign ref_pending_o = pending_q;
    assign ref_ovf_o     = ovf_q;

endmodule

// File: tb/tb_mc_refresh_scheduler.sv
// tb/tb_mc_refresh_scheduler.sv - self-checking bench for mc_refresh_scheduler
module tb_mc_refresh_scheduler;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en = 1'b0;
    logic [11:0] trefi = 12'd0;
    logic [3:0]  post = 4'd0;
    logic [7:0]  trp = 8'd0;
    logic [7:0]  trfc = 8'd0;
    logic        gnt = 1'b0;

    logic        req, urgent, busy, prea, rref, ovf;
    logic [3:0]  pend;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mc_refresh_scheduler #(
        .TREFI_W(12),
        .POST_W (4),
        .T_W    (8)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .ref_en_i          (en),
        .ref_trefi_cfg_i   (trefi),
        .ref_postpone_cfg_i(post),
        .ref_trp_cfg_i     (trp),
        .ref_trfc_cfg_i    (trfc),
        .ref_gnt_i         (gnt),
        .ref_req_o         (req),
        .ref_urgent_o      (urgent),
        .ref_busy_o        (busy),
        .cmd_prea_o        (prea),
        .cmd_ref_o         (rref),
        .ref_pending_o     (pend),
        .ref_ovf_o         (ovf)
    );

    wire [9:0] dut_vec = {req, urgent, busy, prea, rref, ovf, pend};

    // Reference model: debt as an integer, a refresh sequence as an age
    // counted from its PREA cycle with REF and release at fixed offsets.
    int m_cnt = 0;
    int m_pend = 0;
    int m_age = 0;
    int m_rp = 1;
    int m_rfc = 1;
    bit m_busy = 0;
    bit m_ovf = 0;
    bit m_tick, m_cur_ref, m_cur_req;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cnt = 0; m_pend = 0; m_age = 0; m_rp = 1; m_rfc = 1;
            m_busy = 0; m_ovf = 0;
        end else begin
            m_tick    = en && (trefi != 0) && (m_cnt == int'(trefi) - 1);
            m_cur_ref = m_busy && (m_age == m_rp + 1);
            m_cur_req = !m_busy && en && (m_pend != 0);
            if (m_tick && !m_cur_ref) begin
                if (m_pend == 15) m_ovf = 1;
                else m_pend = m_pend + 1;
            end else if (!m_tick && m_cur_ref) begin
                m_pend = m_pend - 1;
            end
            m_cnt = (!en || trefi == 0 || m_tick) ? 0 : m_cnt + 1;
            if (m_busy) begin
                if (m_age == 0) m_rp = (trp == 0) ? 1 : int'(trp);
                if (m_cur_ref) m_rfc = (trfc == 0) ? 1 : int'(trfc);
                m_age = m_age + 1;
                if (m_age == m_rp + 1 + m_rfc + 1) m_busy = 0;
            end else if (m_cur_req && gnt) begin
                m_busy = 1;
                m_age = 0;
            end
        end
    end

    function automatic logic [9:0] exp_vec();
        logic r, u, p, f;
        r = !m_busy && en && (m_pend != 0);
        u = (m_pend >= int'(post)) && (m_pend != 0);
        p = m_busy && (m_age == 0);
        f = m_busy && (m_age == m_rp + 1);
        return {r, u, m_busy, p, f, m_ovf, 4'(m_pend)};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_ni = 1'b0;
        en = 1'b0;
        gnt = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if (dut_vec !== 10'b0) $display("FAIL reset_state got=%b exp=%b", dut_vec, 10'b0);
        else n_pass++;
        rst_ni = 1'b1;
    endtask

    task automatic test_interval_postpone();
        reset_dut();
        trefi = 12'd100; post = 4'd4; trp = 8'd3; trfc = 8'd10; gnt = 1'b0; en = 1'b1;
        for (int e = 1; e <= 450; e++) begin
            step();
            n_total++;
            if (dut_vec !== exp_vec()) $display("FAIL interval_model e=%0d got=%b exp=%b", e, dut_vec, exp_vec());
            else n_pass++;
            if (e == 99 || e == 100 || e == 399 || e == 400) begin
                logic [9:0] want;
                case (e)
                    99:      want = {1'b0, 1'b0, 5'b0, 3'b0} | 10'd0;
                    100:     want = 10'b10_0000_0001;
                    399:     want = 10'b10_0000_0011;
                    default: want = 10'b11_0000_0100;
                endcase
                n_total++;
                if (dut_vec !== want) $display("FAIL interval_boundary e=%0d got=%b exp=%b", e, dut_vec, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sequence();
        reset_dut();
        trefi = 12'd100; post = 4'd4; trp = 8'd3; trfc = 8'd10; gnt = 1'b0; en = 1'b1;
        repeat (100) step();
        gnt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [9:0] want;
            step();
            gnt = 1'b0;
            want = {1'b0, 1'b0, (k <= 14), (k == 0), (k == 4), 1'b0, (k < 5) ? 4'd1 : 4'd0};
            n_total++;
            if (dut_vec !== want) $display("FAIL sequence_timing k=%0d got=%b exp=%b", k, dut_vec, want);
            else n_pass++;
            n_total++;
            if (dut_vec !== exp_vec()) $display("FAIL sequence_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        trefi = 12'd20; post = 4'd15; trp = 8'd3; trfc = 8'd10; gnt = 1'b0; en = 1'b1;
        repeat (34) step();
        gnt = 1'b1;
        for (int e = 35; e < 65; e++) begin
            step();
            gnt = 1'b0;
            n_total++;
            if (dut_vec !== exp_vec()) $display("FAIL b2b_model e=%0d got=%b exp=%b", e, dut_vec, exp_vec());
            else n_pass++;
            if (e == 39) begin
                n_total++;
                if (rref !== 1'b1) $display("FAIL b2b_ref_pulse got=%b exp=1", rref);
                else n_pass++;
            end
            if (e == 40) begin
                n_total++;
                if (pend !== 4'd1) $display("FAIL b2b_pending_hold got=%0d exp=1", pend);
                else n_pass++;
            end
            if (e == 50) begin
                n_total++;
                if ({req, busy} !== 2'b10) $display("FAIL b2b_rereq got=%b exp=10", {req, busy});
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        int last_prea, last_ref, refs;
        logic busy_prev;
        reset_dut();
        trefi = 12'd2; post = 4'd4; trp = 8'd0; trfc = 8'd0; gnt = 1'b0; en = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step();
            n_total++;
            if (dut_vec !== exp_vec()) $display("FAIL sat_model e=%0d got=%b exp=%b", e, dut_vec, exp_vec());
            else n_pass++;
            if (e == 29 || e == 30 || e == 31 || e == 32) begin
                logic [4:0] want;
                want = {(e == 32), (e == 29) ? 4'd14 : 4'd15};
                n_total++;
                if ({ovf, pend} !== want) $display("FAIL sat_boundary e=%0d got=%b exp=%b", e, {ovf, pend}, want);
                else n_pass++;
            end
        end
        trefi = 12'd0;
        gnt = 1'b1;
        last_prea = -100; last_ref = -100; refs = 0; busy_prev = 1'b0;
        for (int e = 0; e < 80; e++) begin
            step();
            n_total++;
            if (dut_vec !== exp_vec()) $display("FAIL drain_model e=%0d got=%b exp=%b", e, dut_vec, exp_vec());
            else n_pass++;
            if (prea) last_prea = e;
            if (rref) begin
                refs++;
                last_ref = e;
                n_total++;
                if (e - last_prea !== 2) $display("FAIL trp_zero_spacing got=%0d exp=2", e - last_prea);
                else n_pass++;
            end
            if (busy_prev && !busy) begin
                n_total++;
                if (e - last_ref !== 2) $display("FAIL trfc_zero_spacing got=%0d exp=2", e - last_ref);
                else n_pass++;
            end
            busy_prev = busy;
        end
        gnt = 1'b0;
        n_total++;
        if ({ovf, pend, busy} !== 6'b1_0000_0) $display("FAIL drain_final got=%b exp=%b", {ovf, pend, busy}, 6'b100000);
        else n_pass++;
        n_total++;
        if (refs !== 15) $display("FAIL drain_ref_count got=%0d exp=15", refs);
        else n_pass++;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        n_total++;
        if ({busy, prea} !== 2'b00) $display("FAIL gnt_without_req got=%b exp=00", {busy, prea});
        else n_pass++;
    endtask

    task automatic test_gnt_disabled();
        reset_dut();
        trefi = 12'd5; post = 4'd3; trp = 8'd2; trfc = 8'd2; gnt = 1'b0; en = 1'b1;
        repeat (5) step();
        en = 1'b0;
        gnt = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step();
            n_total++;
            if ({req, busy, pend} !== 6'b00_0001) $display("FAIL en_low_block e=%0d got=%b exp=%b", e, {req, busy, pend}, 6'b000001);
            else n_pass++;
        end
        gnt = 1'b0;
    endtask

    task automatic test_reset_mid_rfc();
        reset_dut();
        trefi = 12'd10; post = 4'd1; trp = 8'd2; trfc = 8'd20; gnt = 1'b0; en = 1'b1;
        repeat (10) step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        repeat (8) step();
        n_total++;
        if ({busy, pend} !== 5'b1_0000) $display("FAIL pre_reset_busy got=%b exp=%b", {busy, pend}, 5'b10000);
        else n_pass++;
        #2;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if (dut_vec !== 10'b0) $display("FAIL async_reset got=%b exp=%b", dut_vec, 10'b0);
        else n_pass++;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_random();
        reset_dut();
        trefi = 12'd7; post = 4'd3; trp = 8'd2; trfc = 8'd4; gnt = 1'b0; en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            n_total++;
            if (dut_vec !== exp_vec()) $display("FAIL random_model i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
            else n_pass++;
            gnt = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                if (en) begin
                    en = 1'b0;
                    trefi = 12'($urandom_range(0, 25));
                end else begin
                    en = 1'b1;
                end
            end
            if ($urandom_range(0, 29) == 0) post = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                trp  = 8'($urandom_range(0, 6));
                trfc = 8'($urandom_range(0, 12));
            end
        end
    endtask

    initial begin
        test_reset();
        test_interval_postpone();
        test_sequence();
        test_back_to_back();
        test_saturation();
        test_gnt_disabled();
        test_reset_mid_rfc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_refresh_scheduler.md
Name: mc_refresh_scheduler

Overview:
- Sequences all-bank refresh for the LPDDR4 memory controller core, using the CSR refresh timing fields tREFI, POSTPONE, tRP and tRFC.
- Tracks the refresh debt and requests the command slot from the command multiplexer, escalating to urgent when the postpone limit is reached.
- Once granted, issues PREA, waits tRP, issues REF, waits tRFC, then releases the slot.
- Sits between the CSR block and the command multiplexer inside the controller core.

Parameters:
- TREFI_W, 12, width of tREFI config and interval counter.
- POST_W, 4, width of postpone config and pending-refresh counter.
- T_W, 8, width of tRP/tRFC config and timing counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- ref_en  in  1  refresh enable; DFI init complete.
- ref_tREFI_cfg  in  TREFI_W  refresh interval, in clk cycles.
- ref_POSTPONE_cfg  in  POST_W  max pending refreshes before urgent.
- ref_tRP_cfg  in  T_W  PREA-to-REF spacing, in cycles.
- ref_tRFC_cfg  in  T_W  REF-to-release spacing, in cycles.
- ref_gnt  in  1  single-cycle grant from command multiplexer.
- ref_req  out  1  refresh slot request.
- ref_urgent  out  1  pending >= postpone; multiplexer must block new ACT/RD/WR.
- ref_busy  out  1  scheduler owns command bus.
- cmd_prea  out  1  one-cycle precharge-all command pulse.
- cmd_ref  out  1  one-cycle all-bank refresh command pulse.
- ref_pending  out  POST_W  current refresh debt.
- ref_ovf  out  1  sticky: tick arrived with pending saturated.

Behaviour:
- Reset (rst=0, async): all outputs 0, interval counter 0, pending 0, state IDLE.
- Interval counter:
  - Runs only when ref_en=1 and tREFI_cfg!=0; counts 0..tREFI_cfg-1.
  - tick=1 in the cycle count==tREFI_cfg-1; counter then wraps to 0.
  - ref_en=0 or tREFI_cfg=0: counter forced to 0, no ticks.
- Pending counter:
  - +1 on tick; -1 in the cycle cmd_ref=1; tick and cmd_ref in the same cycle leave it unchanged.
  - At max (2^POST_W-1), a tick without cmd_ref holds the value and sets ref_ovf. ref_ovf clears only on reset.
- ref_urgent = (pending >= ref_POSTPONE_cfg) && pending != 0. Combinational from registered pending.
- ref_req = (state==IDLE) && ref_en && pending != 0.
  - Handshake: the grant is accepted only when ref_gnt && ref_req in the same cycle.
  - A ref_gnt without ref_req is ignored.
- State machine (registered):
  - IDLE: on accepted grant -> PRE.
  - PRE (1 cycle): cmd_prea=1, timer loaded with max(tRP_cfg,1)-1 -> WAIT_RP.
  - WAIT_RP: decrement the timer; at 0 -> REF. A 0 load exits after one cycle.
  - REF (1 cycle): cmd_ref=1, timer loaded with max(tRFC_cfg,1)-1 -> WAIT_RFC.
  - WAIT_RFC: decrement the timer; at 0 -> IDLE.
- Timing results:
  - cmd_prea is asserted the cycle after the grant.
  - cmd_ref is asserted exactly max(tRP,1)+1 cycles after cmd_prea.
  - ref_busy is 1 in PRE, WAIT_RP, REF and WAIT_RFC.
  - IDLE is re-entered max(tRFC,1)+1 cycles after cmd_ref.
- Config changes are sampled only at timer-load points; an in-flight sequence is not affected.
- ref_en falling mid-sequence: the sequence completes normally and pending is retained. ref_req stays 0 while ref_en=0.
- Back-to-back refreshes: if pending is still nonzero on return to IDLE, ref_req is reasserted in that same IDLE cycle.
- All outputs are registered except ref_req and ref_urgent, which are decoded from registered state.

Test Plan:
- Reset mid-WAIT_RFC (rst=0 asynchronously) -> all outputs 0 immediately, state IDLE, pending 0, ref_ovf 0.
- tREFI=100, POSTPONE=4, ref_gnt tied 0 for 450 cycles -> first tick at cycle 100. ref_req from cycle 100, pending=4 at cycle 400. ref_urgent=1 from cycle 400.
- pending=1, tRP=3, tRFC=10, grant at cycle T:
  - cmd_prea at T+1 and cmd_ref at T+5.
  - ref_busy high T+1..T+15, IDLE at T+16.
  - pending 0 after T+5.
- Tick coinciding with the cmd_ref cycle -> pending unchanged; ref_req reasserted on return to IDLE.
- tREFI=2, grant withheld -> pending saturates at 15 at cycle 30. ref_ovf set at cycle 32, remaining 1 after grants drain pending.
- tRP=0, tRFC=0 -> treated as 1: cmd_ref 2 cycles after cmd_prea, IDLE 2 cycles after cmd_ref. ref_gnt pulse while ref_req=0 -> no sequence starts.
